// File: rtl/frame_rd_ctrl_if.sv
// Bundle between frame_rd_ctrl, the add_gen counter, the read memory and the downstream sink.
// master = controller side; slave = everything the controller talks to.
interface frame_rd_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              cnt_rst_n;
   logic              cnt_en_n;
   logic [11:0]       addr_in;
   logic              tc_in;
   logic              mem_rd;
   logic [11:0]       mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;

   modport master (
      input  start, abort, addr_in, tc_in, mem_data, dout_ready,
      output busy, done, cnt_rst_n, cnt_en_n, mem_rd, mem_addr, dout, dout_valid
   );

   modport slave (
      output start, abort, addr_in, tc_in, mem_data, dout_ready,
      input  busy, done, cnt_rst_n, cnt_en_n, mem_rd, mem_addr, dout, dout_valid
   );
endinterface

// File: rtl/frame_rd_ctrl.sv
// Streams a 4096-word frame: one read per counter address, first word valid 4 cycles after start.
// Reads are credit-gated by FIFO occupancy plus the in-flight read, so dout_ready stalls never overflow.
module frame_rd_ctrl #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input logic             clock,
   input logic             reset,
   frame_rd_ctrl_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FLUSH} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              busy_q;
   logic              done_q;
   logic              done_nxt;
   logic              inflight;
   logic              issue;
   logic              cnt_clr;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [CW:0]       occupancy;
   logic              credit_ok;

   assign fifo_empty = (fifo_count == '0);
   assign push       = inflight;
   assign pop        = !fifo_empty && bus.dout_ready;
   // Same-cycle pops are deliberately not credited back.
   assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign credit_ok  = (occupancy < DEPTH_L);

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      cnt_clr   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = LOAD;
         end
         LOAD: begin
            cnt_clr = 1'b1;
            state_nxt = bus.abort ? FLUSH : RUN;
         end
         RUN: begin
            if (bus.abort) begin
               state_nxt = FLUSH;
            end else if (credit_ok) begin
               issue = 1'b1;
               if (bus.tc_in) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.abort) begin
               state_nxt = FLUSH;
            end else begin
               // done is registered, so it is armed by the pop that empties the FIFO.
               if (!inflight && fifo_count == CW'(1) && pop) done_nxt = 1'b1;
               if (!inflight && fifo_empty) state_nxt = IDLE;
            end
         end
         FLUSH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         busy_q   <= (state_nxt != IDLE);
         done_q   <= done_nxt;
         inflight <= issue;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else if (state == FLUSH) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_data;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.cnt_rst_n  = !cnt_clr;
   assign bus.cnt_en_n   = !issue;
   assign bus.mem_rd     = issue;
   assign bus.mem_addr   = bus.addr_in;
   assign bus.dout       = fifo_mem[rd_ptr];
   assign bus.dout_valid = !fifo_empty;
endmodule

// File: tb/tb_frame_rd_ctrl.sv
// Bench for frame_rd_ctrl with a behavioural add_gen counter and 1-cycle read memory.
module tb_frame_rd_ctrl;
   localparam int DW    = 8;
   localparam int FRAME = 4096;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   frame_rd_ctrl_if #(.DATA_W(DW)) bus ();

   frame_rd_ctrl #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [DW-1:0] mem_word(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
   endfunction

   logic [11:0] cnt = 12'h777;
   always @(posedge clock) begin
      if (!bus.cnt_rst_n)     cnt <= 12'h000;
      else if (!bus.cnt_en_n) cnt <= cnt + 12'd1;
   end
   assign bus.addr_in = cnt;
   assign bus.tc_in   = (cnt == 12'hFFF);

   always @(posedge clock) begin
      if (bus.mem_rd) bus.mem_data <= mem_word(bus.mem_addr);
      else            bus.mem_data <= DW'($urandom);
   end

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q [$];
   int rel, n_pop, n_rd, n_done, done_cyc, first_valid, first_rd, last_rd;
   int busy_first, busy_last, rd_a, rd_b, rd_42, n_clr, clr_cyc;
   logic [11:0] first_rd_addr;
   bit hold;
   logic [DW-1:0] hold_dat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic obs_clear();
      rel = 0; n_pop = 0; n_rd = 0; n_done = 0; done_cyc = -1;
      first_valid = -1; first_rd = -1; last_rd = -1; first_rd_addr = 12'hABC;
      busy_first = -1; busy_last = -1; rd_a = 0; rd_b = 0; rd_42 = 0;
      n_clr = 0; clr_cyc = -1; hold = 1'b0;
      exp_q.delete();
   endtask

   task automatic load_frame();
      for (int a = 0; a < FRAME; a++) exp_q.push_back(mem_word(12'(a)));
   endtask

   // Observe the cycle whose inputs were just driven, then advance to the next negedge.
   task automatic tick();
      #2;
      if (hold && bus.dout_valid) check("dout_hold", 32'(bus.dout), 32'(hold_dat));
      hold     = bus.dout_valid && !bus.dout_ready;
      hold_dat = bus.dout;
      if (bus.dout_valid && bus.dout_ready) begin
         n_pop++;
         if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
         else                   check("sb_word", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
      if (bus.mem_rd) begin
         n_rd++;
         if (first_rd < 0) begin
            first_rd      = rel;
            first_rd_addr = bus.mem_addr;
         end
         last_rd = rel;
         if (rel < 12)       rd_a++;
         else if (rel <= 41) rd_b++;
         if (rel == 42)      rd_42 = 1;
      end
      if (!bus.cnt_rst_n) begin
         n_clr++;
         clr_cyc = rel;
      end
      if (bus.done) begin
         n_done++;
         done_cyc = rel;
      end
      if (bus.busy) begin
         if (busy_first < 0) busy_first = rel;
         busy_last = rel;
      end
      if (bus.dout_valid && first_valid < 0) first_valid = rel;
      @(negedge clock);
      rel++;
   endtask

   task automatic drive_ready(input int mode);
      case (mode)
         1:       bus.dout_ready = 1'($urandom_range(0, 1));
         2:       bus.dout_ready = !(rel >= 10 && rel <= 40);
         default: bus.dout_ready = 1'b1;
      endcase
   endtask

   task automatic run_frame(input int mode, input bit with_abort);
      obs_clear();
      load_frame();
      bus.start = 1'b1;
      bus.abort = with_abort;
      drive_ready(mode);
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      while (n_done == 0 && rel < 20000) begin
         drive_ready(mode);
         tick();
      end
      drive_ready(mode);
      tick();
      check("frame_done_once", 32'(n_done), 32'd1);
      check("frame_word_count", 32'(n_pop), 32'(FRAME));
      check("frame_sb_empty", 32'(exp_q.size()), 32'd0);
      check("frame_idle_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},       32'(bus.busy),       32'd0);
      check({tag, "_done"},       32'(bus.done),       32'd0);
      check({tag, "_mem_rd"},     32'(bus.mem_rd),     32'd0);
      check({tag, "_cnt_en_n"},   32'(bus.cnt_en_n),   32'd1);
      check({tag, "_cnt_rst_n"},  32'(bus.cnt_rst_n),  32'd1);
      check({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'd0);
      check({tag, "_dout"},       32'(bus.dout),       32'd0);
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.dout_ready = 1'b0;
      obs_clear();
      repeat (3) @(negedge clock);
      check_reset_vals("rst");
      reset = 1'b1;
      @(negedge clock);
      check_reset_vals("post_rst");

      // Full frame, always ready: latency and throughput landmarks.
      run_frame(0, 1'b0);
      check("t1_load_cycle", 32'(clr_cyc), 32'd1);
      check("t1_load_once", 32'(n_clr), 32'd1);
      check("t1_first_rd", 32'(first_rd), 32'd2);
      check("t1_first_addr", 32'(first_rd_addr), 32'd0);
      check("t1_first_valid", 32'(first_valid), 32'd4);
      check("t1_last_rd", 32'(last_rd), 32'd4097);
      check("t1_rd_count", 32'(n_rd), 32'(FRAME));
      check("t1_done_cyc", 32'(done_cyc), 32'd4100);
      check("t1_busy_first", 32'(busy_first), 32'd1);
      check("t1_busy_last", 32'(busy_last), 32'd4100);

      // Stall 10..40: reads stop at occupancy 4 and resume the cycle after the first pop.
      run_frame(2, 1'b0);
      check("t2_rd_before_stall", 32'(rd_a), 32'd10);
      check("t2_rd_during_stall", 32'(rd_b), 32'd0);
      check("t2_rd_resume", 32'(rd_42), 32'd1);

      // Two back-to-back frames with random backpressure.
      run_frame(1, 1'b0);
      check("t3a_first_addr", 32'(first_rd_addr), 32'd0);
      run_frame(1, 1'b0);
      check("t3b_first_addr", 32'(first_rd_addr), 32'd0);

      // Abort in RUN at address 0x123.
      obs_clear();
      load_frame();
      bus.start      = 1'b1;
      bus.dout_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      while (bus.mem_addr != 12'h123 && rel < 1000) tick();
      check("t4_addr_reached", 32'(bus.mem_addr), 32'h123);
      bus.abort = 1'b1;
      #1;
      check("t4_abort_no_rd", 32'(bus.mem_rd), 32'd0);
      check("t4_abort_no_en", 32'(bus.cnt_en_n), 32'd1);
      tick();
      bus.abort = 1'b0;
      check("t4_flush_busy", 32'(bus.busy), 32'd1);
      tick();
      check("t4_idle_valid", 32'(bus.dout_valid), 32'd0);
      check("t4_idle_busy", 32'(bus.busy), 32'd0);
      check("t4_cnt_frozen", 32'(bus.mem_addr), 32'h123);
      exp_q.delete();
      repeat (3) tick();
      check("t4_no_done", 32'(n_done), 32'd0);
      run_frame(0, 1'b0);
      check("t4_restart_addr", 32'(first_rd_addr), 32'd0);
      check("t4_restart_done", 32'(done_cyc), 32'd4100);

      // Abort coinciding with the final pop.
      obs_clear();
      load_frame();
      bus.start      = 1'b1;
      bus.dout_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      while (rel < 4099) tick();
      check("t5_final_valid", 32'(bus.dout_valid), 32'd1);
      check("t5_final_word", 32'(exp_q.size()), 32'd1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      repeat (4) tick();
      check("t5_no_done", 32'(n_done), 32'd0);
      check("t5_idle_busy", 32'(bus.busy), 32'd0);
      check("t5_all_popped", 32'(n_pop), 32'(FRAME));

      // start and abort together in IDLE: start wins.
      run_frame(0, 1'b1);
      check("t5_start_wins_done", 32'(done_cyc), 32'd4100);

      // Asynchronous reset between clock edges.
      obs_clear();
      load_frame();
      bus.start      = 1'b1;
      bus.dout_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      while (rel < 100) tick();
      #2;
      reset = 1'b0;
      #1;
      check_reset_vals("async_rst");
      check("async_rst_addr_pass", 32'(bus.mem_addr), 32'(cnt));
      @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      hold = 1'b0;
      @(negedge clock);
      run_frame(0, 1'b0);
      check("t6_restart_addr", 32'(first_rd_addr), 32'd0);
      check("t6_done_cyc", 32'(done_cyc), 32'd4100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_rd_ctrl.md
# frame_rd_ctrl

Frame read controller that sits directly downstream of the 12-bit address counter (`add_gen`). It drives the counter's active-low clear and count enable and consumes its `addr`/`tc` outputs. It issues one synchronous memory read per address and streams the 4096-word frame out through a small FIFO with a valid/ready handshake. A frame is requested with `start`; `done` pulses once the last word has been accepted downstream.

## Interface
- `DATA_W`, default 8: memory/output data width.
- `FIFO_DEPTH`, default 4: output FIFO depth; power of 2, minimum 2.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `abort`  in  1  cancels the current frame.
- `busy`  out  1  high from LOAD through DRAIN/FLUSH.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `cnt_rst_n`  out  1  drives the counter's `reset` (synchronous clear, active-low).
- `cnt_en_n`  out  1  drives the counter's `enable` (active-low: count when 0).
- `addr_in`  in  12  counter `addr`.
- `tc_in`  in  1  counter `tc` (high when `addr_in` is 12'hFFF).
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  12  equal to `addr_in` (combinational pass-through).
- `mem_data`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd`.
- `dout`  out  DATA_W  FIFO head.
- `dout_valid`  out  1  FIFO not empty.
- `dout_ready`  in  1  downstream accept.

## Operation
- States:
  - IDLE: `start`=1 goes to LOAD.
  - LOAD: 1 cycle, `cnt_rst_n`=0 clears the counter to 0; goes to RUN.
  - RUN: issue reads.
  - DRAIN: wait until no read is in flight and the FIFO is empty, pulse `done`, then go to IDLE.
  - FLUSH: abort path, described below.
- Issue rule (RUN only):
  - `mem_rd`=1 and `cnt_en_n`=0 in the same cycle when `fifo_count + inflight < FIFO_DEPTH`.
  - A pop in the same cycle is not credited, so the FIFO can never overflow.
  - `inflight` is 0 or 1: it is the registered copy of `mem_rd`.
- Last read: a read issued while `tc_in`=1 is the last read of the frame, and the FSM moves to DRAIN. The counter wraps to 0 on the same edge.
- FIFO behaviour:
  - Push when `inflight`=1, capturing `mem_data`.
  - Pop when `dout_valid` and `dout_ready` are both 1.
  - Simultaneous push and pop are legal at any occupancy and leave the count unchanged.
- Word count: exactly 4096 words per frame, in address order 0..4095.
- Abort:
  - In LOAD, RUN or DRAIN, stop issuing and go to FLUSH.
  - FLUSH lasts 1 cycle: any in-flight datum is discarded, the FIFO is cleared, the FSM returns to IDLE, and no `done` pulse is produced.
  - Abort in IDLE has no effect.
  - If `start` and `abort` arrive together in IDLE, `start` wins.
  - If `abort` coincides with the final pop, `abort` wins and `done` is suppressed.
- `start` outside IDLE is ignored.
- `dout_valid` never depends combinationally on `dout_ready`.
- `dout` is held stable while `dout_valid`=1 and `dout_ready`=0.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`=0, `done`=0, `mem_rd`=0, `cnt_en_n`=1, `cnt_rst_n`=1, `dout_valid`=0, `dout`=0.
  - FIFO is empty and `inflight`=0.
- Reset asserted mid-frame returns to the reset values immediately.
  - The counter is not cleared by this block until the next LOAD.
- Latency, with `start` seen in cycle 0:
  - Cycle 1 is LOAD.
  - Cycle 2 issues the first read at address 0.
  - Cycle 3: `mem_data` valid and pushed into the FIFO.
  - Cycle 4: `dout_valid`=1.
- Throughput with `dout_ready`=1 throughout:
  - One read per cycle.
  - Last read in cycle 4097, last word accepted in cycle 4099, `done` in cycle 4100, IDLE in cycle 4101.
- Outputs:
  - `busy` is registered.
  - `done` is registered and is high exactly 1 cycle.
  - `mem_rd` and `cnt_en_n` are combinational from state and the credit check.
  - `cnt_rst_n` is low only in LOAD.

## Test plan
- Reset, then `start` with `dout_ready`=1 → 4096 words equal to mem[0..4095] in order. First `dout_valid` in cycle 4, `done` only in cycle 4100, `busy` high in cycles 1..4100.
- `dout_ready` low for cycles 10..40 → `mem_rd` stops once `fifo_count + inflight` = 4, with no word lost or duplicated. Reads resume one cycle after the first pop.
- Random 50% `dout_ready` over two back-to-back frames → both frames are complete and in order. The second frame starts at address 0 because LOAD clears the counter.
- `abort` in RUN at address 0x123 → one FLUSH cycle, then `dout_valid`=0, `busy`=0 and no `done`. A following `start` streams from address 0.
- `abort` coinciding with the final pop → no `done` pulse. `start`+`abort` together in IDLE → frame runs normally.
- Asynchronous `reset` pulse mid-frame, between clock edges → all outputs at reset values before the next edge. `start` afterwards gives a full 4096-word frame.
